// File: rtl/tdo_capture.sv
// TDO capture: packs tdo_valid bits LSB-first into J_D_WIDTH-bit RAM words; write issues one clk after the filling bit, done one clk later.
// No backpressure (1 bit/clk accepted); optional captured_bits port under `TDO_CAPTURE_COUNT_EN.
module tdo_capture #(
   parameter int J_D_WIDTH = 8,
   parameter int J_A_WIDTH = 12
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 capture_start,
   input  logic                 capture_abort,
   input  logic [J_A_WIDTH+2:0] capture_bits,
   input  logic                 tdo,
   input  logic                 tdo_valid,
   output logic [J_A_WIDTH-1:0] vector_2_addr,
   output logic                 vector_2_we,
   output logic [J_D_WIDTH-1:0] vector_2_wr_data,
`ifdef TDO_CAPTURE_COUNT_EN
   output logic [J_A_WIDTH+2:0] captured_bits,
`endif
   output logic                 busy,
   output logic                 done
);

   localparam int CW = J_A_WIDTH + 3;
   localparam int PW = (J_D_WIDTH > 1) ? $clog2(J_D_WIDTH) : 1;
   localparam logic [PW-1:0] POS_LAST = PW'(J_D_WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      CAPTURE = 2'd1,
      FLUSH   = 2'd2,
      DONE    = 2'd3
   } state_t;

   state_t               state_q;
   logic [CW-1:0]        rem_q;
   logic [PW-1:0]        pos_q;
   logic [J_D_WIDTH-1:0] shreg_q;
   logic [J_A_WIDTH-1:0] addr_q;
   logic                 we_q;
   logic [J_D_WIDTH-1:0] wdata_q;
   logic                 busy_q;
   logic                 done_q;

   logic [J_D_WIDTH-1:0] word_d;
   logic                 bit_acc;
   logic                 last_bit;
   logic                 word_full;

   always_comb begin
      word_d        = shreg_q;
      word_d[pos_q] = tdo;
   end

   assign bit_acc   = (state_q == CAPTURE) && tdo_valid;
   assign last_bit  = (rem_q == CW'(1));
   assign word_full = (pos_q == POS_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         rem_q   <= '0;
         pos_q   <= '0;
         shreg_q <= '0;
         addr_q  <= '0;
         we_q    <= 1'b0;
         wdata_q <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         we_q   <= 1'b0;
         done_q <= 1'b0;
         // Address advances at the end of each write cycle, so it reads as the write target while we is high.
         if (we_q) begin
            addr_q <= addr_q + J_A_WIDTH'(1);
         end
         if (capture_abort) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               IDLE: begin
                  if (capture_start) begin
                     rem_q   <= capture_bits;
                     pos_q   <= '0;
                     shreg_q <= '0;
                     addr_q  <= '0;
                     if (capture_bits == '0) begin
                        state_q <= DONE;
                     end else begin
                        state_q <= CAPTURE;
                        busy_q  <= 1'b1;
                     end
                  end
               end
               CAPTURE: begin
                  if (bit_acc) begin
                     rem_q <= rem_q - CW'(1);
                     if (word_full || last_bit) begin
                        we_q    <= 1'b1;
                        wdata_q <= word_d;
                        shreg_q <= '0;
                        pos_q   <= '0;
                     end else begin
                        shreg_q <= word_d;
                        pos_q   <= pos_q + PW'(1);
                     end
                     if (last_bit) begin
                        state_q <= FLUSH;
                     end
                  end
               end
               FLUSH: begin
                  state_q <= DONE;
                  busy_q  <= 1'b0;
                  done_q  <= 1'b1;
               end
               DONE: begin
                  // A zero-length capture reaches DONE without the pulse FLUSH issues, so raise it here instead.
                  state_q <= IDLE;
                  done_q  <= !done_q;
               end
               default: state_q <= IDLE;
            endcase
         end
      end
   end

`ifdef TDO_CAPTURE_COUNT_EN
   logic [CW-1:0] cnt_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q <= '0;
      end else if (!capture_abort) begin
         if ((state_q == IDLE) && capture_start) begin
            cnt_q <= '0;
         end else if (bit_acc) begin
            cnt_q <= cnt_q + CW'(1);
         end
      end
   end

   assign captured_bits = cnt_q;
`endif

   assign vector_2_addr    = addr_q;
   assign vector_2_we      = we_q;
   assign vector_2_wr_data = wdata_q;
   assign busy             = busy_q;
   assign done             = done_q;

endmodule

// File: tb/tb_tdo_capture.sv
// Bench for tdo_capture: constant vector table, hand sequences, and random captures against a word-packing model.
module tb_tdo_capture;

   localparam int DW = 8;
   localparam int AW = 12;
   localparam int CW = AW + 3;

   logic          clk = 1'b0;
   logic          reset = 1'b1;
   logic          capture_start = 1'b0;
   logic          capture_abort = 1'b0;
   logic [CW-1:0] capture_bits = '0;
   logic          tdo = 1'b0;
   logic          tdo_valid = 1'b0;
   logic [AW-1:0] vector_2_addr;
   logic          vector_2_we;
   logic [DW-1:0] vector_2_wr_data;
   logic          busy;
   logic          done;
`ifdef TDO_CAPTURE_COUNT_EN
   logic [CW-1:0] captured_bits;
`endif

   tdo_capture #(.J_D_WIDTH(DW), .J_A_WIDTH(AW)) dut (
      .clk              (clk),
      .reset            (reset),
      .capture_start    (capture_start),
      .capture_abort    (capture_abort),
      .capture_bits     (capture_bits),
      .tdo              (tdo),
      .tdo_valid        (tdo_valid),
      .vector_2_addr    (vector_2_addr),
      .vector_2_we      (vector_2_we),
      .vector_2_wr_data (vector_2_wr_data),
`ifdef TDO_CAPTURE_COUNT_EN
      .captured_bits    (captured_bits),
`endif
      .busy             (busy),
      .done             (done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // Event log, filled only by this monitor; runs index it from recorded bases.
   int wr_a[$];
   int wr_d[$];
   int wr_c[$];
   int done_c[$];
   int done_busy[$];
   int busy_cnt = 0;

   always @(negedge clk) begin
      if (vector_2_we) begin
         wr_a.push_back(int'(vector_2_addr));
         wr_d.push_back(int'(vector_2_wr_data));
         wr_c.push_back(cyc);
      end
      if (done) begin
         done_c.push_back(cyc);
         done_busy.push_back(int'(busy));
      end
      if (busy) busy_cnt = busy_cnt + 1;
   end

   int n_checks = 0;
   int n_errors = 0;
   bit bits_arr[32768];
   int exp_q[$];
   int wb, db, bb, start_cyc, abort_cyc;

   typedef struct {
      int          nbits;
      int          gap;
      int          abort_after;
      int          junk;
      int          restart_at;
      int          trail;
      logic [31:0] pattern;
      int          exp_nw;
      int          exp_w0;
      int          exp_w1;
      int          exp_done;
      int          exp_cnt;
   } vec_t;

   vec_t tbl[8];

   task automatic check(input string name, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic mark();
      wb = wr_c.size();
      db = done_c.size();
      bb = busy_cnt;
   endtask

   task automatic run_capture(input int nbits, input int gap, input int abort_after,
                              input int junk, input int restart_at, input int trail);
      mark();
      abort_cyc = -1;
      for (int i = 0; i < junk; i++) begin
         tdo = 1'b1;
         tdo_valid = 1'b1;
         step();
      end
      tdo_valid = 1'b0;
      capture_bits = CW'(nbits);
      capture_start = 1'b1;
      start_cyc = cyc;
      step();
      capture_start = 1'b0;
      capture_bits = CW'($urandom);
      if (nbits > 0) check("busy after start", int'(busy), 1);
      for (int i = 0; i < nbits; i++) begin
         if (i == abort_after) break;
         if (i == restart_at) begin
            capture_start = 1'b1;
            capture_bits = CW'(3);
         end
         tdo = bits_arr[i];
         tdo_valid = 1'b1;
         step();
         tdo_valid = 1'b0;
         capture_start = 1'b0;
         for (int g = 0; g < gap; g++) step();
      end
      if (abort_after >= 0 && abort_after < nbits) begin
         capture_abort = 1'b1;
         abort_cyc = cyc;
         step();
         capture_abort = 1'b0;
         check("busy after abort", int'(busy), 0);
      end
      for (int i = 0; i < trail; i++) begin
         tdo = 1'b1;
         tdo_valid = 1'b1;
         step();
      end
      tdo_valid = 1'b0;
      for (int i = 0; i < 8; i++) step();
   endtask

   task automatic check_capture(input string tag, input int exp_done, input int exp_cnt, input bit aborted);
      int nw, nd, bc;
      nw = wr_c.size() - wb;
      nd = done_c.size() - db;
      bc = busy_cnt - bb;
      check({tag, " writes"}, nw, exp_q.size());
      for (int i = 0; i < nw && i < exp_q.size(); i++) begin
         check($sformatf("%s addr%0d", tag, i), wr_a[wb+i], i);
         check($sformatf("%s data%0d", tag, i), wr_d[wb+i], exp_q[i]);
      end
      check({tag, " done pulses"}, nd, exp_done);
      if (aborted) begin
         check({tag, " busy cycles"}, bc, abort_cyc - start_cyc);
      end else if (nd >= 1) begin
         if (nw == 0) check({tag, " done latency"}, done_c[db], start_cyc + 2);
         else         check({tag, " done latency"}, done_c[db], wr_c[wb+nw-1] + 1);
         check({tag, " busy at done"}, done_busy[db], 0);
         check({tag, " busy cycles"}, bc, (nw == 0) ? 0 : done_c[db] - start_cyc - 1);
      end
      check({tag, " busy idle"}, int'(busy), 0);
`ifdef TDO_CAPTURE_COUNT_EN
      check({tag, " captured_bits"}, int'(captured_bits), exp_cnt);
`else
      if (exp_cnt < 0) check({tag, " count arg"}, exp_cnt, 0);
`endif
   endtask

   // Expected words straight from the packing rule: bit i lands in word i/8 at position i%8.
   task automatic model(input int n, input int abort_after, output int cnt);
      int m, nw, val;
      exp_q.delete();
      if (abort_after >= 0 && abort_after < n) begin
         m = abort_after;
         nw = m / DW;
      end else begin
         m = n;
         nw = (n + DW - 1) / DW;
      end
      for (int w = 0; w < nw; w++) begin
         val = 0;
         for (int b = 0; b < DW; b++) begin
            if (w * DW + b < m) val = val + int'(bits_arr[w*DW+b]) * (1 << b);
         end
         exp_q.push_back(val);
      end
      cnt = m;
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " addr"}, int'(vector_2_addr), 0);
      check({tag, " we"}, int'(vector_2_we), 0);
      check({tag, " wdata"}, int'(vector_2_wr_data), 0);
      check({tag, " busy"}, int'(busy), 0);
      check({tag, " done"}, int'(done), 0);
`ifdef TDO_CAPTURE_COUNT_EN
      check({tag, " captured_bits"}, int'(captured_bits), 0);
`endif
   endtask

   initial begin
      int n, gap, ab, junk, rs, trail, cnt;

      //          nbits gap abort junk rst trail pattern       nw  w0     w1     done cnt
      tbl[0] = '{16,   0,  -1,   0,  -1,  0,   32'h0000_3CA5, 2, 'hA5,  'h3C,  1,   16};
      tbl[1] = '{11,   3,  -1,   0,  -1,  0,   32'h0000_07FF, 2, 'hFF,  'h07,  1,   11};
      tbl[2] = '{20,   0,  10,   0,  -1,  0,   32'h000A_BCDE, 1, 'hDE,  'h00,  0,   10};
      tbl[3] = '{8,    1,  -1,   0,  -1,  3,   32'h0000_0081, 1, 'h81,  'h00,  1,   8};
      tbl[4] = '{16,   0,  -1,   4,   6,  2,   32'h0000_5A96, 2, 'h96,  'h5A,  1,   16};
      tbl[5] = '{9,    2,  -1,   0,  -1,  0,   32'h0000_0100, 2, 'h00,  'h01,  1,   9};
      tbl[6] = '{1,    0,  -1,   0,  -1,  0,   32'h0000_0001, 1, 'h01,  'h00,  1,   1};
      tbl[7] = '{13,   0,   8,   0,  -1,  0,   32'h0000_1F0F, 1, 'h0F,  'h00,  0,   8};

      for (int i = 0; i < 3; i++) step();
      check_reset_outputs("reset");
      reset = 1'b0;
      step();

      for (int t = 0; t < 8; t++) begin
         for (int i = 0; i < 32; i++) bits_arr[i] = tbl[t].pattern[i];
         exp_q.delete();
         if (tbl[t].exp_nw >= 1) exp_q.push_back(tbl[t].exp_w0);
         if (tbl[t].exp_nw >= 2) exp_q.push_back(tbl[t].exp_w1);
         run_capture(tbl[t].nbits, tbl[t].gap, tbl[t].abort_after,
                     tbl[t].junk, tbl[t].restart_at, tbl[t].trail);
         check_capture($sformatf("vec%0d", t), tbl[t].exp_done, tbl[t].exp_cnt,
                       tbl[t].abort_after >= 0 && tbl[t].abort_after < tbl[t].nbits);
      end

      // Zero-length capture: done only, two cycles after start.
      exp_q.delete();
      run_capture(0, 0, -1, 0, -1, 2);
      check_capture("zero", 1, 0, 1'b0);

      // Abort and start together: abort wins, following bits are ignored.
      mark();
      capture_bits = CW'(8);
      capture_start = 1'b1;
      capture_abort = 1'b1;
      step();
      capture_start = 1'b0;
      capture_abort = 1'b0;
      check("abort+start busy", int'(busy), 0);
      for (int i = 0; i < 8; i++) begin
         tdo = 1'b1;
         tdo_valid = 1'b1;
         step();
      end
      tdo_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("abort+start writes", wr_c.size() - wb, 0);
      check("abort+start done", done_c.size() - db, 0);
      check("abort+start busy cycles", busy_cnt - bb, 0);

      // Reset mid-capture, with tdo_valid held through and after release.
      mark();
      capture_bits = CW'(8);
      capture_start = 1'b1;
      step();
      capture_start = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tdo = 1'b1;
         tdo_valid = 1'b1;
         step();
      end
      reset = 1'b1;
      step();
      check_reset_outputs("midreset");
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) step();
      tdo_valid = 1'b0;
      for (int i = 0; i < 4; i++) step();
      check("midreset writes", wr_c.size() - wb, 0);
      check("midreset done", done_c.size() - db, 0);
      check("midreset busy", int'(busy), 0);

      for (int r = 0; r < 40; r++) begin
         n = $urandom_range(0, 40);
         gap = $urandom_range(0, 2);
         ab = ($urandom_range(0, 3) == 0 && n > 1) ? $urandom_range(0, n - 1) : -1;
         junk = $urandom_range(0, 2);
         rs = ($urandom_range(0, 1) == 1 && n > 2) ? $urandom_range(1, n - 1) : -1;
         trail = $urandom_range(0, 3);
         for (int i = 0; i < n; i++) bits_arr[i] = 1'($urandom_range(0, 1));
         model(n, ab, cnt);
         run_capture(n, gap, ab, junk, rs, trail);
         check_capture($sformatf("rnd%0d", r), (ab >= 0) ? 0 : 1, cnt, ab >= 0);
      end

      reset = 1'b1;
      step();
      check_reset_outputs("late reset");
      step();
      reset = 1'b0;
      step();

      // Largest capture: fills every RAM word exactly once.
      n = (1 << CW) - 1;
      for (int i = 0; i < n; i++) bits_arr[i] = 1'($urandom_range(0, 1));
      model(n, -1, cnt);
      run_capture(n, 0, -1, 0, -1, 0);
      check_capture("maxlen", 1, cnt, 1'b0);

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/tdo_capture.md
TDO_CAPTURE -- requirements
Module: tdo_capture

Interface
REQ-001 Parameter J_D_WIDTH, default 8, SHALL set the vector RAM data width, i.e. TDO bits packed per RAM word.
REQ-002 Parameter J_A_WIDTH, default 12, SHALL set the vector RAM address width.
REQ-003 clk  in  1  SHALL be the single clock; all logic is rising-edge.
REQ-004 reset  in  1  SHALL be a synchronous, active-high reset.
REQ-005 capture_start  in  1  SHALL be a one-cycle pulse that begins a capture.
REQ-006 capture_abort  in  1  SHALL be a level or pulse that terminates a capture.
REQ-007 capture_bits  in  J_A_WIDTH+3  SHALL give the number of TDO bits to record; it is sampled on capture_start.
REQ-008 tdo  in  1  SHALL carry the sampled TDO bit from jtag_signal_out.
REQ-009 tdo_valid  in  1  SHALL be a one-cycle strobe, synchronous to clk, marking tdo as a new bit.
REQ-010 vector_2_addr  out  J_A_WIDTH  SHALL carry the result RAM write address.
REQ-011 vector_2_we  out  1  SHALL be the result RAM write enable.
REQ-012 vector_2_wr_data  out  J_D_WIDTH  SHALL carry the result RAM write data.
REQ-013 busy  out  1  SHALL be high from the cycle after an accepted start until done or abort.
REQ-014 done  out  1  SHALL be a one-cycle pulse when the final word has been written.

Function
REQ-015 States SHALL be IDLE, CAPTURE, FLUSH and DONE.
- IDLE->CAPTURE on capture_start with capture_bits!=0.
- IDLE->DONE on capture_start with capture_bits==0; no RAM write occurs.
- CAPTURE->FLUSH when the last bit is accepted.
- FLUSH->DONE after the final write.
- DONE->IDLE unconditionally.
REQ-016 On an accepted start, the block SHALL latch capture_bits, clear the bit counter, word index, shift register and address, and set busy on the next cycle.
REQ-017 In CAPTURE, each tdo_valid SHALL place tdo at bit position (bit_count mod J_D_WIDTH), LSB first, and increment bit_count.
REQ-018 When a word fills (position J_D_WIDTH-1) or the last bit arrives, vector_2_we SHALL pulse for exactly one cycle, on the cycle after that tdo_valid, with the completed word and the current address; the address SHALL then increment.
REQ-019 In a partial last word, unused upper bits SHALL be 0.
REQ-020 Back-to-back tdo_valid on consecutive cycles SHALL be accepted with no bit loss; throughput is 1 bit/clk.
REQ-021 tdo_valid in IDLE, FLUSH or DONE SHALL be ignored.
REQ-022 capture_start while busy SHALL be ignored.
REQ-023 capture_abort in any state SHALL force IDLE on the next cycle: busy=0, no done, no further writes. A pending partial word is discarded.
REQ-024 If abort and start are asserted together, abort SHALL win.
REQ-025 done SHALL assert one cycle after the final vector_2_we; busy SHALL fall in the same cycle that done asserts.
REQ-026 The word count written SHALL equal ceil(capture_bits/J_D_WIDTH). The maximum capture_bits, 2^(J_A_WIDTH+3)-1, SHALL fit the RAM without address wrap.

Reset
REQ-027 While reset is high, the state SHALL be IDLE, and vector_2_addr, vector_2_we, vector_2_wr_data, busy and done SHALL all be 0.
REQ-028 Reset mid-capture SHALL discard the capture; no write SHALL occur in the cycle after reset deasserts.

Configuration
REQ-029 With macro TDO_CAPTURE_COUNT_EN defined, an output captured_bits [J_A_WIDTH+2:0] SHALL exist.
- It holds the number of bits accepted in the current or last capture.
- It is cleared on start and on reset, and holds its value after done or abort.
- Without the macro, the port and its counter logic SHALL be absent, and all other behaviour SHALL be identical.

Verification
REQ-030 Start with capture_bits=16, then 16 back-to-back tdo_valid with pattern 0xA5 then 0x3C, LSB first:
- two writes: addr0=0xA5, addr1=0x3C;
- done one cycle after the second write.
REQ-031 Start with capture_bits=11, bits all 1, spaced by 3 idle clocks:
- writes addr0=0xFF, addr1=0x07;
- exactly two we pulses.
REQ-032 Start with capture_bits=0:
- done pulses two cycles after start;
- no vector_2_we; busy stays 0.
REQ-033 Start with capture_bits=20, abort after 10 bits:
- exactly one write (addr0); no done; busy=0 next cycle;
- a new start then writes from addr0.
REQ-034 Second capture_start mid-capture, plus tdo_valid in IDLE:
- both ignored; output words unchanged.
REQ-035 Reset asserted after 5 bits of capture_bits=8:
- all outputs 0; no write after release;
- with TDO_CAPTURE_COUNT_EN, captured_bits=0.
